// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-port arbiter in front of the shared ALU.
// State encoding, flag bit positions and the ALU control codes used by requesters.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int FLG_ZERO  = 3;
  localparam int FLG_CARRY = 2;
  localparam int FLG_NEG   = 1;
  localparam int FLG_OVF   = 0;

  // Field order mirrors the FLG_* bit indices.
  typedef struct packed {
    logic zero;
    logic carry;
    logic negative;
    logic overflow;
  } flags_t;

  localparam logic [3:0] ALUC_ADDU = 4'b0000;
  localparam logic [3:0] ALUC_SUBU = 4'b0001;
  localparam logic [3:0] ALUC_AND  = 4'b0100;
  localparam logic [3:0] ALUC_OR   = 4'b0101;

endpackage

// File: rtl/alu_arb_rr_arb2.sv
// Two-requester grant logic: lone valid wins; on contention the port not granted last wins
// when enable is high, otherwise port 0 wins. Purely combinational, no backpressure of its own.
module alu_rr_arb2 (
  input  logic [1:0] valid,
  input  logic [0:0] last,
  input  logic       enable,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (enable && (last[0] == 1'b0)) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arb.sv
// Shares one external ALU between two request ports; response visible two edges after the
// handshake cycle starts, requests stalled until the response is consumed. ALU_ARB_RR_EN = round-robin.
module alu_arb
  import alu_arb_pkg::*;
#(
  parameter int DW = 32,
  parameter int CW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2*DW-1:0]   req_a,
  input  logic [2*DW-1:0]   req_b,
  input  logic [2*CW-1:0]   req_aluc,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DW-1:0]     rsp_r,
  output logic [3:0]        rsp_flags,
  output logic [DW-1:0]     alu_a,
  output logic [DW-1:0]     alu_b,
  output logic [CW-1:0]     alu_aluc,
  input  logic [DW-1:0]     alu_r,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_negative,
  input  logic              alu_overflow
);

  state_t          state_q, state_d;
  logic [DW-1:0]   a_q, a_d, b_q, b_d, r_q, r_d;
  logic [CW-1:0]   aluc_q, aluc_d;
  logic            g_q, g_d;
  flags_t          flags_q, flags_d;
  logic [0:0]      last_q, last_d;
  logic            rr_en;
  logic [1:0]      grant;
  logic            accept;
  logic            sel;

`ifdef ALU_ARB_RR_EN
  assign rr_en = 1'b1;
  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end
`else
  assign rr_en  = 1'b0;
  assign last_q = 1'b1;
`endif

  alu_rr_arb2 u_arb (
    .valid  (req_valid),
    .last   (last_q),
    .enable (rr_en),
    .grant  (grant)
  );

  assign sel    = grant[1];
  assign accept = |(req_valid & req_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      aluc_q  <= '0;
      g_q     <= 1'b0;
      r_q     <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      aluc_q  <= aluc_d;
      g_q     <= g_d;
      r_q     <= r_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_DONE;
      ST_DONE: if (rsp_ready[g_q]) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand/result capture; the winner's slice is chosen by the grant index.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    aluc_d  = aluc_q;
    g_d     = g_q;
    r_d     = r_q;
    flags_d = flags_q;
    last_d  = last_q;
    if (state_q == ST_IDLE && accept) begin
      a_d    = sel ? req_a[2*DW-1:DW]    : req_a[DW-1:0];
      b_d    = sel ? req_b[2*DW-1:DW]    : req_b[DW-1:0];
      aluc_d = sel ? req_aluc[2*CW-1:CW] : req_aluc[CW-1:0];
      g_d    = sel;
      last_d = sel;
    end
    if (state_q == ST_EXEC) begin
      r_d     = alu_r;
      flags_d = '{zero: alu_zero, carry: alu_carry,
                  negative: alu_negative, overflow: alu_overflow};
    end
  end

  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    if (state_q == ST_IDLE && !rst) req_ready = grant;
    if (state_q == ST_DONE)         rsp_valid = g_q ? 2'b10 : 2'b01;
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_aluc  = aluc_q;
  assign rsp_r     = r_q;
  assign rsp_flags = flags_q;

endmodule

// File: tb/tb_alu_arb.sv
// Directed bench for alu_arb with a behavioural ALU model on the shared-ALU side.
module tb_alu_arb;
  import alu_arb_pkg::*;

  localparam int DW = 32;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2*DW-1:0] req_a, req_b;
  logic [2*CW-1:0] req_aluc;
  logic [DW-1:0]   rsp_r, alu_a, alu_b, alu_r;
  logic [3:0]      rsp_flags;
  logic [CW-1:0]   alu_aluc;
  logic            alu_zero, alu_carry, alu_negative, alu_overflow;
  logic [DW:0]     sum;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  alu_arb #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_aluc(req_aluc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_r(rsp_r), .rsp_flags(rsp_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc),
    .alu_r(alu_r), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_negative(alu_negative), .alu_overflow(alu_overflow)
  );

  always_comb begin
    sum          = '0;
    alu_r        = '0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_aluc)
      ALUC_ADDU: begin
        sum          = {1'b0, alu_a} + {1'b0, alu_b};
        alu_r        = sum[DW-1:0];
        alu_carry    = sum[DW];
        alu_overflow = (alu_a[DW-1] == alu_b[DW-1]) && (alu_r[DW-1] != alu_a[DW-1]);
      end
      ALUC_SUBU: begin
        alu_r        = alu_a - alu_b;
        alu_carry    = (alu_a < alu_b);
        alu_overflow = (alu_a[DW-1] != alu_b[DW-1]) && (alu_r[DW-1] != alu_a[DW-1]);
      end
      ALUC_AND: alu_r = alu_a & alu_b;
      ALUC_OR:  alu_r = alu_a | alu_b;
      default:  alu_r = '0;
    endcase
    alu_zero     = (alu_r == '0);
    alu_negative = alu_r[DW-1];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b11; rsp_ready = 2'b00;
    req_a = '0; req_b = '0; req_aluc = '0;
    tick(); tick();
    checks++; if (req_ready !== 2'b00) $display("FAIL reset_req_ready got %b want 00", req_ready); else passes++;
    checks++; if (rsp_valid !== 2'b00) $display("FAIL reset_rsp_valid got %b want 00", rsp_valid); else passes++;
    checks++; if (rsp_r !== 32'd0) $display("FAIL reset_rsp_r got %0d want 0", rsp_r); else passes++;
    checks++; if (rsp_flags !== 4'b0000) $display("FAIL reset_flags got %b want 0000", rsp_flags); else passes++;
    checks++; if (alu_a !== 32'd0 || alu_aluc !== 4'd0) $display("FAIL reset_operands got a=%0d c=%0d want 0", alu_a, alu_aluc); else passes++;
    rst = 1'b0; req_valid = 2'b00;
    tick();
  endtask

  task automatic test_port0_add();
    req_a = {32'd0, 32'd5}; req_b = {32'd0, 32'd7}; req_aluc = {4'd0, ALUC_ADDU};
    req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) $display("FAIL p0_ready got %b want 01", req_ready); else passes++;
    tick();
    req_valid = 2'b00;
    checks++; if (alu_a !== 32'd5 || alu_b !== 32'd7 || alu_aluc !== ALUC_ADDU)
      $display("FAIL p0_exec_operands got a=%0d b=%0d c=%0d want 5 7 %0d", alu_a, alu_b, alu_aluc, ALUC_ADDU); else passes++;
    checks++; if (rsp_valid !== 2'b00 || req_ready !== 2'b00)
      $display("FAIL p0_exec_hs got rv=%b rr=%b want 00 00", rsp_valid, req_ready); else passes++;
    tick();
    checks++; if (rsp_valid !== 2'b01) $display("FAIL p0_rsp_valid got %b want 01", rsp_valid); else passes++;
    checks++; if (rsp_r !== 32'd12) $display("FAIL p0_rsp_r got %0d want 12", rsp_r); else passes++;
    checks++; if (rsp_flags !== 4'b0000) $display("FAIL p0_flags got %b want 0000", rsp_flags); else passes++;
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    checks++; if (rsp_valid !== 2'b00) $display("FAIL p0_consumed got %b want 00", rsp_valid); else passes++;
  endtask

  task automatic test_port1_sub_hold();
    req_a = {32'd9, 32'd0}; req_b = {32'd9, 32'd0}; req_aluc = {ALUC_SUBU, 4'd0};
    req_valid = 2'b10;
    #1;
    checks++; if (req_ready !== 2'b10) $display("FAIL p1_ready got %b want 10", req_ready); else passes++;
    tick();
    req_valid = 2'b00;
    tick();
    checks++; if (rsp_valid !== 2'b10) $display("FAIL p1_rsp_valid got %b want 10", rsp_valid); else passes++;
    checks++; if (rsp_r !== 32'd0) $display("FAIL p1_rsp_r got %0d want 0", rsp_r); else passes++;
    checks++; if (rsp_flags[FLG_ZERO] !== 1'b1 || rsp_flags !== 4'b1000) $display("FAIL p1_flags got %b want 1000", rsp_flags); else passes++;
    // Other port's ready and fresh requests must not disturb a pending response.
    req_valid = 2'b11; rsp_ready = 2'b01;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (rsp_valid !== 2'b10 || rsp_r !== 32'd0 || rsp_flags !== 4'b1000 || req_ready !== 2'b00)
        $display("FAIL hold_%0d got rv=%b r=%0d f=%b rr=%b want 10 0 1000 00", i, rsp_valid, rsp_r, rsp_flags, req_ready); else passes++;
    end
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;
    checks++; if (rsp_valid !== 2'b00 || req_ready === 2'b00)
      $display("FAIL hold_release got rv=%b rr=%b want 00 nonzero", rsp_valid, req_ready); else passes++;
    req_valid = 2'b00;
    #1;
  endtask

  task automatic test_arbitration();
    logic [1:0]    exp_g;
    logic [DW-1:0] exp_r;
    int            n;
    rst = 1'b1; tick(); rst = 1'b0;
    req_a = {32'd10, 32'd1}; req_b = {32'd4, 32'd2}; req_aluc = {ALUC_SUBU, ALUC_ADDU};
    req_valid = 2'b11; rsp_ready = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_RR_EN
      exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
`else
      exp_g = 2'b01;
`endif
      exp_r = (exp_g == 2'b10) ? 32'd6 : 32'd3;
      n = 0;
      while (req_ready === 2'b00 && n < 10) begin tick(); n++; end
      checks++; if (req_ready !== exp_g) $display("FAIL arb_grant_%0d got %b want %b", k, req_ready, exp_g); else passes++;
      tick(); tick();
      checks++; if (rsp_valid !== exp_g || rsp_r !== exp_r)
        $display("FAIL arb_rsp_%0d got rv=%b r=%0d want %b %0d", k, rsp_valid, rsp_r, exp_g, exp_r); else passes++;
      tick();
    end
    req_valid = 2'b00; rsp_ready = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid();
    req_a = {32'd0, 32'd5}; req_b = {32'd0, 32'd7}; req_aluc = {ALUC_SUBU, ALUC_ADDU};
    req_valid = 2'b01;
    tick();
    req_valid = 2'b11; rst = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b00) $display("FAIL rstmid_ready_in_rst got %b want 00", req_ready); else passes++;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (rsp_valid !== 2'b00 || rsp_r !== 32'd0)
      $display("FAIL rstmid_discard got rv=%b r=%0d want 00 0", rsp_valid, rsp_r); else passes++;
    checks++; if (req_ready !== 2'b01) $display("FAIL rstmid_next_grant got %b want 01", req_ready); else passes++;
    tick();
    req_valid = 2'b00;
    tick();
    checks++; if (rsp_valid !== 2'b01 || rsp_r !== 32'd12)
      $display("FAIL rstmid_rsp got rv=%b r=%0d want 01 12", rsp_valid, rsp_r); else passes++;
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_port0_add();
    test_port1_sub_hold();
    test_arbitration();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 Parameter: DW, 32, operand/result width; SHALL match the shared ALU width.
REQ-002 Parameter: CW, 4, ALU control code width (aluc).
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 req_valid  in  2  per-port request valid; bit i belongs to port i.
REQ-007 req_ready  out  2  per-port request accepted this cycle.
REQ-008 req_a, req_b  in  2*DW  packed operands, {port1,port0}.
REQ-009 req_aluc  in  2*CW  packed ALU control, {port1,port0}.
REQ-010 rsp_valid  out  2  per-port response valid.
REQ-011 rsp_ready  in  2  per-port response consumed.
REQ-012 rsp_r  out  DW  result of the granted port's operation.
REQ-013 rsp_flags  out  4  {zero,carry,negative,overflow} of that operation.
REQ-014 alu_a, alu_b  out  DW  operands driven to the shared ALU.
REQ-015 alu_aluc  out  CW  control code driven to the shared ALU.
REQ-016 alu_r  in  DW; alu_zero, alu_carry, alu_negative, alu_overflow  in  1 each; combinational ALU outputs.

Function
REQ-017 The FSM SHALL have three states: IDLE, EXEC, DONE.
REQ-018 In IDLE, req_ready SHALL be one-hot to the winning port when any req_valid is high, else 0; ready MAY depend combinationally on valid.
REQ-019 A request is accepted when req_valid[i] & req_ready[i]; the block SHALL then register a, b, aluc and grant index g, and move to EXEC.
REQ-020 In EXEC, alu_a/alu_b/alu_aluc SHALL carry the registered operands; at the cycle's end the block SHALL capture alu_r and the four flags, then move to DONE.
REQ-021 In DONE, rsp_valid[g] SHALL be 1, the other bit 0; rsp_r/rsp_flags SHALL hold steady until rsp_ready[g], which returns the FSM to IDLE.
REQ-022 rsp_ready on the non-granted port SHALL be ignored.
REQ-023 Latency: accept at edge N -> rsp_valid high from edge N+2; minimum issue interval 3 cycles.
REQ-024 req_ready SHALL be 0 in EXEC and DONE; alu_* outputs SHALL hold their last registered values outside EXEC.
REQ-025 Arbitration: single valid port wins; with both valid, the winner follows REQ-031/032.
REQ-026 A requester SHALL NOT change a/b/aluc while valid and not ready; the block does not check this.

Reset
REQ-027 On rst: FSM -> IDLE, req_ready=0 for that cycle, rsp_valid=0, rsp_r=0, rsp_flags=0, operand registers=0, last-grant pointer=1.
REQ-028 Reset mid-operation (EXEC or DONE) SHALL discard the transaction with no response.
REQ-029 rst SHALL dominate every simultaneous request or response event.

Configuration
REQ-030 Macro ALU_ARB_RR_EN selects the arbitration policy.
REQ-031 Defined: round-robin; with both valid, the port not granted last wins; the pointer updates on each accept only.
REQ-032 Undefined: fixed priority, port 0 always wins; the pointer register is not required.

Structure
REQ-033 Package alu_arb_pkg SHALL hold state encoding, flag bit indices (FLG_ZERO=3, FLG_CARRY=2, FLG_NEG=1, FLG_OVF=0) and ALU control constants ALUC_ADDU, ALUC_SUBU, ALUC_AND, ALUC_OR.
REQ-034 Grant logic SHALL be a sub-module alu_rr_arb2: inputs valid[1:0], last[0:0], enable; outputs grant[1:0].
REQ-035 The ALU itself is instantiated outside this block; alu_arb contains no arithmetic.

Verification
REQ-036 Port0 only: a=5, b=7, ALUC_ADDU, accept at edge N -> rsp_valid=2'b01 at N+2, rsp_r=12, flags=4'b0000.
REQ-037 Port1 SUBU 9-9 -> rsp_valid=2'b10, rsp_r=0, rsp_flags[FLG_ZERO]=1.
REQ-038 Both ports valid continuously, rsp_ready=2'b11, RR_EN defined -> grants alternate 0,1,0,1; without macro -> four grants to port 0.
REQ-039 Hold rsp_ready[g]=0 for 5 cycles in DONE -> rsp_r/flags stable, req_ready=0 throughout; release -> IDLE next edge.
REQ-040 Assert rst during EXEC -> next edge: rsp_valid=0, rsp_r=0, FSM IDLE; the following accept goes to port 0 when both are valid.
